// File: rtl/bcd_serial_add_sub.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_sub
//
// Digit-serial packed-BCD adder/subtractor. An accepted start latches both
// operands and the mode. The block then processes one decimal digit per clock,
// starting with the least significant digit, and rippling a decimal
// carry/borrow between digits.
//
// Parameters
//   DIGITS : number of packed BCD digits per operand (1..16)
//
// Ports
//   clk    : clock; all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : operation request; only looked at while idle
//   mode   : 0 = A+B, 1 = A-B; captured together with start
//   a, b   : packed BCD operands, digit 0 in bits [3:0]
//   result : packed BCD sum/difference; valid from done until next start
//   cout   : decimal carry out (add) or final borrow (subtract)
//   busy   : high while digits are being processed
//   done   : single-cycle completion pulse
//   err    : a latched operand contained a digit greater than 9
// ---------------------------------------------------------------------------
module bcd_serial_add_sub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] result,
    output logic                cout,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               c_q, c_d;
    logic [W-1:0]       result_q, result_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Per-digit validity check on the live operand inputs, used only on the
    // accepting edge.
    logic [DIGITS-1:0]  digit_bad;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_chk
            assign digit_bad[gi] = (a[gi*4 +: 4] > 4'd9) || (b[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    // Current digit pair, selected by shifting the latched operands down.
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [4:0]         sum_t;
    logic [4:0]         dif_t;
    logic [3:0]         dig_out;
    logic               c_next;

    assign a_sh  = a_q >> {idx_q, 2'b00};
    assign b_sh  = b_q >> {idx_q, 2'b00};
    assign a_dig = a_sh[3:0];
    assign b_dig = b_sh[3:0];

    // 5-bit arithmetic: sum range 0..19, difference range -10..9 (bit 4 is
    // the sign for the subtract path).
    assign sum_t = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, c_q};
    assign dif_t = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, c_q};

    always_comb begin
        dig_out = 4'd0;
        c_next  = 1'b0;
        if (err_q) begin
            // Invalid operands: run the full latency but produce zeros.
            dig_out = 4'd0;
            c_next  = 1'b0;
        end else if (!mode_q) begin
            if (sum_t > 5'd9) begin
                // t - 10 is the same as t + 6 modulo 16 for t in 10..19.
                dig_out = sum_t[3:0] + 4'd6;
                c_next  = 1'b1;
            end else begin
                dig_out = sum_t[3:0];
                c_next  = 1'b0;
            end
        end else begin
            if (dif_t[4]) begin
                // Low nibble holds t + 16; adding 10 modulo 16 gives t + 10.
                dig_out = dif_t[3:0] + 4'd10;
                c_next  = 1'b1;
            end else begin
                dig_out = dif_t[3:0];
                c_next  = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        c_d      = c_q;
        result_d = result_q;
        cout_d   = cout_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    a_d      = a;
                    b_d      = b;
                    mode_d   = mode;
                    idx_d    = '0;
                    c_d      = 1'b0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    err_d    = |digit_bad;
                end
            end

            S_CALC: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*4 +: 4] = dig_out;
                    end
                end
                c_d = c_next;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    state_d = S_DONE;
                    cout_d  = c_next;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered decodes of the next state so they
        // line up exactly with the state they describe.
        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            c_q      <= c_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_bcd_serial_add_sub.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_sub
//
// Directed bench for bcd_serial_add_sub. It instantiates a 4-digit DUT and a
// 1-digit DUT. Expected values come from a decimal model that converts the
// BCD operands to integers, does plain arithmetic, and converts back. The
// negedge process tracks the expected busy/done timeline and the held outputs
// of the 4-digit DUT. The 1-digit DUT is swept exhaustively.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_sub;

    localparam int D = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, mode;
    logic [15:0] a, b, result;
    logic        cout, busy, done, err;

    logic        start1, mode1;
    logic [3:0]  a1, b1, result1;
    logic        cout1, busy1, done1, err1;

    bcd_serial_add_sub #(.DIGITS(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .a(a), .b(b), .result(result), .cout(cout),
        .busy(busy), .done(done), .err(err)
    );

    bcd_serial_add_sub #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
        .a(a1), .b(b1), .result(result1), .cout(cout1),
        .busy(busy1), .done(done1), .err(err1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: BCD -> integer, arithmetic modulo 10^nd, -> BCD.
    function automatic void bcd_model(input int nd, input bit m,
                                      input logic [63:0] av, input logic [63:0] bv,
                                      output logic [63:0] r, output logic co,
                                      output logic er);
        longint ai = 0, bi = 0, p = 1, x;
        logic [3:0] da, db;
        er = 1'b0;
        for (int i = 0; i < nd; i++) begin
            da = av[i*4 +: 4];
            db = bv[i*4 +: 4];
            if (da > 4'd9 || db > 4'd9) er = 1'b1;
            ai += longint'(da) * p;
            bi += longint'(db) * p;
            p  *= 10;
        end
        r  = '0;
        co = 1'b0;
        if (er) return;
        if (!m) begin
            x  = ai + bi;
            co = (x >= p);
            if (co) x -= p;
        end else begin
            x  = ai - bi;
            co = (x < 0);
            if (co) x += p;
        end
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

    // Expected-timeline state shared between driver and checker.
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          in_flight = 1'b0;
    bit          hold      = 1'b0;
    int          accept_cyc = 0;
    logic [15:0] exp_r = '0;
    logic        exp_c = 1'b0;
    logic        exp_e = 1'b0;

    // Compare process for the 4-digit DUT.
    always @(negedge clk) begin
        int ph;
        if (in_flight) begin
            ph = cyc - accept_cyc;
            if (ph < D) begin
                chk("busy_calc", busy, 1);
                chk("done_calc", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("busy_in_done", busy, 0);
                chk("result", result, exp_r);
                chk("cout", cout, exp_c);
                chk("err", err, exp_e);
                in_flight = 1'b0;
                hold      = 1'b1;
            end
        end else begin
            chk("busy_idle", busy, 0);
            chk("done_idle", done, 0);
            if (hold) begin
                chk("hold_result", result, exp_r);
                chk("hold_cout", cout, exp_c);
                chk("hold_err", err, exp_e);
            end
        end
    end

    // Called just after the accepting edge.
    task automatic begin_tracking(input bit m, input logic [15:0] av, input logic [15:0] bv);
        logic [63:0] r;
        logic        co, er;
        bcd_model(D, m, 64'(av), 64'(bv), r, co, er);
        exp_r      = r[15:0];
        exp_c      = co;
        exp_e      = er;
        accept_cyc = cyc;
        hold       = 1'b0;
        in_flight  = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (in_flight && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (in_flight) begin
            chk("done_timeout", 1, 0);
            in_flight = 1'b0;
        end
    endtask

    task automatic run_op(input bit m, input logic [15:0] av, input logic [15:0] bv,
                          input bit inject);
        @(negedge clk);
        start = 1'b1; mode = m; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin_tracking(m, av, bv);
        if (inject) begin
            // New request while busy must be ignored.
            @(negedge clk);
            start = 1'b1; mode = ~m; a = 16'h9999; b = 16'h8888;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic set_zero_expect();
        in_flight = 1'b0;
        hold      = 1'b1;
        exp_r     = '0;
        exp_c     = 1'b0;
        exp_e     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic        co, er;
        int          k;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        start1 = 1'b0; mode1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state.
        @(posedge clk);
        #1;
        set_zero_expect();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Literal pins on the model itself.
        bcd_model(4, 1'b0, 64'h1234, 64'h5678, r, co, er);
        chk("pin_add", {r[15:0], 3'b000, co}, {16'h6912, 4'h0});
        bcd_model(4, 1'b1, 64'h0001, 64'h0002, r, co, er);
        chk("pin_sub_borrow", {r[15:0], 3'b000, co}, {16'h9999, 4'h1});
        bcd_model(1, 1'b1, 64'h3, 64'h7, r, co, er);
        chk("pin_sub1", {r[3:0], 3'b000, co}, {4'h6, 4'h1});

        // Directed vectors with hand-computed results.
        run_op(1'b0, 16'h1234, 16'h5678, 1'b0);
        chk("lit_1234p5678", {result, 3'b000, cout}, {16'h6912, 4'h0});
        run_op(1'b0, 16'h9999, 16'h0001, 1'b0);
        chk("lit_9999p0001", {result, 3'b000, cout}, {16'h0000, 4'h1});
        run_op(1'b1, 16'h5000, 16'h0001, 1'b0);
        chk("lit_5000m0001", {result, 3'b000, cout}, {16'h4999, 4'h0});
        run_op(1'b1, 16'h0001, 16'h0002, 1'b0);
        chk("lit_0001m0002", {result, 3'b000, cout}, {16'h9999, 4'h1});
        run_op(1'b0, 16'h12A4, 16'h0001, 1'b0);
        chk("lit_err", {result, 2'b00, err, cout}, {16'h0000, 4'h2});
        run_op(1'b0, 16'h2222, 16'h3333, 1'b1);
        chk("lit_ignore_start", {result, 3'b000, cout}, {16'h5555, 4'h0});

        // Reset pulse while idx = 2.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        begin_tracking(1'b0, 16'h1234, 16'h5678);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_zero_expect();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_result", result, 16'h0000);
        run_op(1'b0, 16'h0456, 16'h0789, 1'b0);
        chk("lit_after_rst", {result, 3'b000, cout}, {16'h1245, 4'h0});

        // Reset and start on the same edge: reset wins, then start is
        // accepted on the first edge after release.
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; mode = 1'b1; a = 16'h0500; b = 16'h0250;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_zero_expect();
        chk("rst_start_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        begin_tracking(1'b1, 16'h0500, 16'h0250);
        wait_done();
        chk("lit_0500m0250", {result, 3'b000, cout}, {16'h0250, 4'h0});

        // Exhaustive single-digit sweep plus one invalid-digit case.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 11; x++) begin
                for (int y = 0; y < 10; y++) begin
                    @(negedge clk);
                    start1 = 1'b1; mode1 = m[0];
                    a1 = (x == 10) ? 4'hC : 4'(x);
                    b1 = 4'(y);
                    @(posedge clk);
                    #1;
                    start1 = 1'b0;
                    bcd_model(1, m[0], 64'(a1), 64'(b1), r, co, er);
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!done1 && k < 6);
                    chk("sw_latency", k, 2);
                    chk("sw_result", result1, r[3:0]);
                    chk("sw_cout", cout1, co);
                    chk("sw_err", err1, er);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
